serial_to_parallel_rx: RTL



---
 rtl/serial_to_parallel_rx.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_to_parallel_rx.sv
// Serial link receiver: finds byte alignment on a comma symbol, locks after a run
// of aligned commas, then presents each received byte with a valid flag.
module serial_to_parallel_rx #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned COMMA_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       word_strobe,
    output logic       active,
    output logic [2:0] bit_cnt_out
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] LOCK_COUNT = 4'(COMMA_COUNT);

    logic [1:0] state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] comma_cnt;

    // Word as it will look once the bit being sampled on this edge is shifted in.
    logic [7:0] nxt;
    logic       is_comma;
    logic       boundary;

    assign nxt      = {sr[6:0], data_in};
    assign is_comma = (nxt == COMMA);
    assign boundary = (bit_cnt == 3'd7);

    assign bit_cnt_out = bit_cnt;

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking writes would let later statements see this edge's new values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_SEARCH;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            comma_cnt   <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            word_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr          <= nxt;
            word_strobe <= 1'b0;

            case (state)
                ST_SEARCH: begin
                    // Any bit offset may match; the match fixes the word phase.
                    if (is_comma) begin
                        comma_cnt <= 4'd1;
                        bit_cnt   <= 3'd0;
                        if (LOCK_COUNT == 4'd1) begin
                            state  <= ST_ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ST_ALIGN;
                        end
                    end
                end

                ST_ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        word_strobe <= 1'b1;
                        if (is_comma) begin
                            comma_cnt <= comma_cnt + 4'd1;
                            if (comma_cnt + 4'd1 == LOCK_COUNT) begin
                                state  <= ST_ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            // Broken comma run: drop the byte and hunt again.
                            state     <= ST_SEARCH;
                            comma_cnt <= 4'd0;
                            bit_cnt   <= 3'd0;
                        end
                    end
                end

                ST_ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        word_strobe <= 1'b1;
                        if (is_comma) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= nxt;
                            valid_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= ST_SEARCH;
                    bit_cnt   <= 3'd0;
                    comma_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
